apu_sample_capture: RTL and testbench
=====================================

# apu_sample_capture

Downstream consumer of the APU audio output path: samples the 8-bit channel code presented to the AUX DAC input (e.g. `{4'b0000, SQ_Out}`) once per sample strobe, box-car accumulates a fixed power-of-two window, and pushes each window sum as a left-aligned 16-bit PCM word into a small first-word-fall-through FIFO with a valid/ready output handshake. It turns square/triangle/noise channel runs into a decimated sample stream for dump and comparison against reference audio.

## Interface
- `DECIM_LOG2`, 5: log2 of strobes per output sample (window = 32); legal range 0..8.
- `FIFO_LOG2`, 2: log2 of FIFO depth (depth = 4); legal range 1..4.

- `CLK`  in  1  sole clock; all state updates on posedge.
- `n_RES`  in  1  reset, asynchronous, active-low.
- `SMP`  in  1  sample strobe, one CLK cycle wide (driver derives it from ACLK1 rising).
- `AIN`  in  8  channel code to accumulate; sampled only when `SMP`=1.
- `CLR`  in  1  synchronous clear; dominates `SMP` and the handshake.
- `OUT_READY`  in  1  consumer accepts the head word.
- `OUT_VALID`  out  1  FIFO not empty.
- `OUT_DATA`  out  16  FIFO head word; 0 when empty.
- `LEVEL`  out  FIFO_LOG2+1  FIFO occupancy, 0..depth.
- `OVF`  out  1  sticky: a completed window was dropped.

## Operation
- State: accumulator `acc` (8+DECIM_LOG2 bits, cannot overflow), window counter `cnt` (DECIM_LOG2 bits), FIFO array, write/read pointers (FIFO_LOG2+1 bits each), `OVF`.
- `SMP`=1 and `cnt` < 2^DECIM_LOG2-1: `acc` <= `acc`+`AIN`; `cnt` <= `cnt`+1.
- `SMP`=1 and `cnt` = 2^DECIM_LOG2-1 (window end): word = (`acc`+`AIN`) << (8-DECIM_LOG2), zero-filled, 16 bits; push request; `acc` <= 0; `cnt` <= 0 (wrap). DECIM_LOG2=0: every strobe is a window end, word = `AIN`<<8.
- Pop: `OUT_VALID` & `OUT_READY` at a posedge removes the head.
- Push when not full: accepted. Push when full and pop same cycle: both happen, `LEVEL` stays at depth, no overflow. Push when full without pop: word discarded, `OVF` <= 1, FIFO unchanged; window counter still wraps normally.
- Pop with `OUT_VALID`=0: ignored. `OUT_READY` held high on empty FIFO has no effect.
- `OVF` clears only on `n_RES` or `CLR`.
- `CLR`=1: `acc`, `cnt`, pointers, `OVF` <= 0; concurrent `SMP` and pop ignored.
- Pointers wrap modulo 2*depth; full = MSBs differ and low bits equal; empty = pointers equal.

## Timing
- Reset (`n_RES`=0, immediate): `acc`=0, `cnt`=0, `LEVEL`=0, `OUT_VALID`=0, `OUT_DATA`=0, `OVF`=0. Reset mid-window discards the partial sum; first window after release spans exactly 2^DECIM_LOG2 strobes.
- Latency: window-end strobe at edge N -> `OUT_VALID`=1 and `OUT_DATA` valid after edge N (FWFT, no extra read cycle) if FIFO was empty.
- `OUT_DATA`/`OUT_VALID` are registered-state-driven (decoded from pointers and array, no combinational path from `OUT_READY` or `AIN`).
- Pop at edge M: next head (or 0 / `OUT_VALID`=0) visible after edge M; back-to-back pops with `OUT_READY` held high drain one word per cycle.
- `LEVEL` updates on the same edge as the push/pop it reflects.
- `SMP` on consecutive cycles is legal; each counts as one strobe.

## Test plan
- Default params, `AIN`=6 constant, 32 strobes, `OUT_READY`=1 -> one word 0x0600 (192<<3), `OUT_VALID` high one cycle after the 32nd strobe; 33 strobes still yield exactly one word.
- `AIN`=0xFF for 32 strobes -> 0xFF00; `AIN` alternating 0/15 -> 240<<3 = 0x0780.
- `OUT_READY`=0, five windows with `AIN`=1,2,3,4,5 -> `LEVEL`=4, `OVF`=1 after fifth window end; then drain -> 0x0100, 0x0200, 0x0300, 0x0400, `OUT_VALID` falls, `OVF` stays 1.
- FIFO full, window end on same edge as pop -> `LEVEL` remains 4, `OVF` stays 0, new word appears last in drain order.
- 10 strobes of `AIN`=9, then `n_RES` pulse low (async, between edges), then 32 strobes of `AIN`=1 -> single word 0x0100; all outputs 0 during reset.
- `CLR` asserted on the same edge as a window-end strobe and a pop with `LEVEL`=2, `OVF`=1 -> `LEVEL`=0, `OVF`=0, no word pushed, next window starts at `cnt`=0.

Source files
------------

// File: rtl/apu_sample_capture.sv
// Purpose: box-car accumulate 2^DECIM_LOG2 strobed AIN codes into left-aligned 16-bit PCM words, queued in a FWFT FIFO.
// Latency: the word from a window-end strobe at edge N is on OUT_DATA/OUT_VALID right after edge N when the FIFO was empty.
// Backpressure: OUT_VALID/OUT_READY handshake; a window completing into a full FIFO without a pop is dropped and sets sticky OVF.
module apu_sample_capture #(
    parameter int DECIM_LOG2 = 5,
    parameter int FIFO_LOG2  = 2
) (
    input  logic                 CLK,
    input  logic                 n_RES,
    input  logic                 SMP,
    input  logic [7:0]           AIN,
    input  logic                 CLR,
    input  logic                 OUT_READY,
    output logic                 OUT_VALID,
    output logic [15:0]          OUT_DATA,
    output logic [FIFO_LOG2:0]   LEVEL,
    output logic                 OVF
);

    localparam int AW    = 8 + DECIM_LOG2;
    // Keep the counter at least one bit wide so DECIM_LOG2=0 still elaborates;
    // in that case it sits at 0 and every strobe is a window end.
    localparam int CW    = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int PW    = FIFO_LOG2 + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << DECIM_LOG2) - 1);

    logic [AW-1:0]  acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic           ovf_q, ovf_d;
    logic [15:0]    fifo_mem [DEPTH];

    logic           fifo_empty;
    logic           fifo_full;
    logic           win_end;
    logic           pop;
    logic           push_ok;
    logic [AW-1:0]  win_sum;
    logic [15:0]    win_word;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FIFO_LOG2] != rd_ptr_q[FIFO_LOG2]) &&
                        (wr_ptr_q[FIFO_LOG2-1:0] == rd_ptr_q[FIFO_LOG2-1:0]);

    // Accumulator width is 8+DECIM_LOG2, so the window sum can never wrap.
    assign win_sum  = acc_q + AW'(AIN);
    assign win_word = 16'(win_sum) << (8 - DECIM_LOG2);

    // CLR masks both the window-end push and the pop.
    assign win_end = !CLR && SMP && (cnt_q == CNT_LAST);
    assign pop     = !CLR && !fifo_empty && OUT_READY;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push_ok = win_end && (!fifo_full || pop);

    // Next-state: clear dominates, then accumulation, pop and push/overflow.
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (CLR) begin
            acc_d    = '0;
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
        end else begin
            if (SMP) begin
                if (cnt_q == CNT_LAST) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else begin
                    acc_d = win_sum;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else if (win_end) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage needs no reset: contents are only visible through the pointers.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q[FIFO_LOG2-1:0]] <= win_word;
        end
    end

    // Outputs decode registered state only; the head reads as zero when empty.
    assign OUT_VALID = !fifo_empty;
    assign OUT_DATA  = fifo_empty ? 16'h0000 : fifo_mem[rd_ptr_q[FIFO_LOG2-1:0]];
    assign LEVEL     = wr_ptr_q - rd_ptr_q;
    assign OVF       = ovf_q;

endmodule

// File: tb/tb_apu_sample_capture.sv
// Bench for apu_sample_capture: directed vector table, corner-case sequences,
// then randomized traffic compared against a strobe-counting queue model.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_apu_sample_capture;

    localparam int D     = 5;
    localparam int F     = 2;
    localparam int WIN   = 1 << D;
    localparam int DEPTH = 1 << F;

    logic         CLK = 1'b0;
    logic         n_RES;
    logic         SMP;
    logic [7:0]   AIN;
    logic         CLR;
    logic         OUT_READY;
    logic         OUT_VALID;
    logic [15:0]  OUT_DATA;
    logic [F:0]   LEVEL;
    logic         OVF;

    apu_sample_capture #(.DECIM_LOG2(D), .FIFO_LOG2(F)) dut (
        .CLK       (CLK),
        .n_RES     (n_RES),
        .SMP       (SMP),
        .AIN       (AIN),
        .CLR       (CLR),
        .OUT_READY (OUT_READY),
        .OUT_VALID (OUT_VALID),
        .OUT_DATA  (OUT_DATA),
        .LEVEL     (LEVEL),
        .OVF       (OVF)
    );

    always #5 CLK = ~CLK;

    int nchk = 0;
    int nerr = 0;

    // Reference model: running sum, strobe count within window, word queue.
    int          m_sum;
    int          m_n;
    logic [15:0] m_q[$];
    bit          m_ovf;

    function automatic void model_reset();
        m_sum = 0;
        m_n   = 0;
        m_q.delete();
        m_ovf = 1'b0;
    endfunction

    // Apply the current inputs as they will be seen at the coming rising edge.
    function automatic void model_step();
        bit          popping;
        bit          push;
        int          pre;
        logic [31:0] w;
        if (CLR) begin
            model_reset();
            return;
        end
        pre     = m_q.size();
        popping = (pre > 0) && OUT_READY;
        push    = 1'b0;
        w       = 32'd0;
        if (SMP) begin
            m_sum = m_sum + int'(AIN);
            m_n   = m_n + 1;
            if (m_n == WIN) begin
                w     = 32'(m_sum) << (8 - D);
                push  = 1'b1;
                m_sum = 0;
                m_n   = 0;
            end
        end
        if (popping) void'(m_q.pop_front());
        if (push) begin
            if (pre < DEPTH || popping) m_q.push_back(w[15:0]);
            else m_ovf = 1'b1;
        end
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".valid"}, int'(OUT_VALID), int'(m_q.size() != 0));
        chk({tag, ".data"},  int'(OUT_DATA),  (m_q.size() != 0) ? int'(m_q[0]) : 0);
        chk({tag, ".level"}, int'(LEVEL),     m_q.size());
        chk({tag, ".ovf"},   int'(OVF),       int'(m_ovf));
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input bit smp, input logic [7:0] ain, input bit clr, input bit rdy);
        SMP       = smp;
        AIN       = ain;
        CLR       = clr;
        OUT_READY = rdy;
    endtask

    typedef struct {
        bit          smp;
        logic [7:0]  ain;
        bit          clr;
        bit          rdy;
        int          reps;
        bit          e_vld;
        logic [15:0] e_data;
        int          e_lvl;
        bit          e_ovf;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(bit smp, logic [7:0] ain, bit clr, bit rdy, int reps,
                                bit e_vld, logic [15:0] e_data, int e_lvl, bit e_ovf);
        vec_t v;
        v.smp = smp; v.ain = ain; v.clr = clr; v.rdy = rdy; v.reps = reps;
        v.e_vld = e_vld; v.e_data = e_data; v.e_lvl = e_lvl; v.e_ovf = e_ovf;
        return v;
    endfunction

    initial begin
        int rdy_pct;

        // Table rows: inputs held for reps cycles, outputs checked after the last one.
        // Single window of 6s, then a 33rd strobe that must not produce a word.
        tab.push_back(mk(1, 8'd6,   0, 1, 31, 0, 16'h0000, 0, 0));
        tab.push_back(mk(1, 8'd6,   0, 1, 1,  1, 16'h0600, 1, 0));
        tab.push_back(mk(0, 8'd0,   0, 1, 1,  0, 16'h0000, 0, 0));
        tab.push_back(mk(1, 8'd6,   0, 1, 1,  0, 16'h0000, 0, 0));
        tab.push_back(mk(0, 8'd0,   0, 1, 20, 0, 16'h0000, 0, 0));
        // Full-scale window.
        tab.push_back(mk(0, 8'd0,   1, 0, 1,  0, 16'h0000, 0, 0));
        tab.push_back(mk(1, 8'hFF,  0, 0, 32, 1, 16'hFF00, 1, 0));
        tab.push_back(mk(0, 8'd0,   0, 1, 1,  0, 16'h0000, 0, 0));
        // Five windows into a stalled FIFO, then drain.
        tab.push_back(mk(1, 8'd1,   0, 0, 32, 1, 16'h0100, 1, 0));
        tab.push_back(mk(1, 8'd2,   0, 0, 32, 1, 16'h0100, 2, 0));
        tab.push_back(mk(1, 8'd3,   0, 0, 32, 1, 16'h0100, 3, 0));
        tab.push_back(mk(1, 8'd4,   0, 0, 32, 1, 16'h0100, 4, 0));
        tab.push_back(mk(1, 8'd5,   0, 0, 32, 1, 16'h0100, 4, 1));
        tab.push_back(mk(0, 8'd0,   0, 1, 1,  1, 16'h0200, 3, 1));
        tab.push_back(mk(0, 8'd0,   0, 1, 1,  1, 16'h0300, 2, 1));
        tab.push_back(mk(0, 8'd0,   0, 1, 1,  1, 16'h0400, 1, 1));
        tab.push_back(mk(0, 8'd0,   0, 1, 1,  0, 16'h0000, 0, 1));
        tab.push_back(mk(0, 8'd0,   0, 1, 3,  0, 16'h0000, 0, 1));
        // Full FIFO: window end coincides with a pop.
        tab.push_back(mk(0, 8'd0,   1, 0, 1,  0, 16'h0000, 0, 0));
        tab.push_back(mk(1, 8'd1,   0, 0, 32, 1, 16'h0100, 1, 0));
        tab.push_back(mk(1, 8'd2,   0, 0, 32, 1, 16'h0100, 2, 0));
        tab.push_back(mk(1, 8'd3,   0, 0, 32, 1, 16'h0100, 3, 0));
        tab.push_back(mk(1, 8'd4,   0, 0, 32, 1, 16'h0100, 4, 0));
        tab.push_back(mk(1, 8'd6,   0, 0, 31, 1, 16'h0100, 4, 0));
        tab.push_back(mk(1, 8'd6,   0, 1, 1,  1, 16'h0200, 4, 0));
        tab.push_back(mk(0, 8'd0,   0, 1, 1,  1, 16'h0300, 3, 0));
        tab.push_back(mk(0, 8'd0,   0, 1, 1,  1, 16'h0400, 2, 0));
        tab.push_back(mk(0, 8'd0,   0, 1, 1,  1, 16'h0600, 1, 0));
        tab.push_back(mk(0, 8'd0,   0, 1, 1,  0, 16'h0000, 0, 0));
        // CLR collides with a window end and a pop at LEVEL=2, OVF=1.
        tab.push_back(mk(0, 8'd0,   1, 0, 1,  0, 16'h0000, 0, 0));
        tab.push_back(mk(1, 8'd1,   0, 0, 32, 1, 16'h0100, 1, 0));
        tab.push_back(mk(1, 8'd2,   0, 0, 32, 1, 16'h0100, 2, 0));
        tab.push_back(mk(1, 8'd3,   0, 0, 32, 1, 16'h0100, 3, 0));
        tab.push_back(mk(1, 8'd4,   0, 0, 32, 1, 16'h0100, 4, 0));
        tab.push_back(mk(1, 8'd5,   0, 0, 32, 1, 16'h0100, 4, 1));
        tab.push_back(mk(0, 8'd0,   0, 1, 2,  1, 16'h0300, 2, 1));
        tab.push_back(mk(1, 8'd7,   0, 0, 31, 1, 16'h0300, 2, 1));
        tab.push_back(mk(1, 8'd7,   1, 1, 1,  0, 16'h0000, 0, 0));
        tab.push_back(mk(1, 8'd1,   0, 0, 31, 0, 16'h0000, 0, 0));
        tab.push_back(mk(1, 8'd1,   0, 0, 1,  1, 16'h0100, 1, 0));
        tab.push_back(mk(0, 8'd0,   0, 1, 1,  0, 16'h0000, 0, 0));

        // Reset: outputs must be zero while n_RES is low.
        drive(0, 8'd0, 0, 0);
        n_RES = 1'b0;
        model_reset();
        #12;
        chk("reset.valid", int'(OUT_VALID), 0);
        chk("reset.data",  int'(OUT_DATA),  0);
        chk("reset.level", int'(LEVEL),     0);
        chk("reset.ovf",   int'(OVF),       0);
        n_RES = 1'b1;
        tick();

        // Directed vector table.
        for (int i = 0; i < tab.size(); i++) begin
            for (int r = 0; r < tab[i].reps; r++) begin
                drive(tab[i].smp, tab[i].ain, tab[i].clr, tab[i].rdy);
                tick();
            end
            chk($sformatf("tab%0d.valid", i), int'(OUT_VALID), int'(tab[i].e_vld));
            chk($sformatf("tab%0d.data", i),  int'(OUT_DATA),  int'(tab[i].e_data));
            chk($sformatf("tab%0d.level", i), int'(LEVEL),     tab[i].e_lvl);
            chk($sformatf("tab%0d.ovf", i),   int'(OVF),       int'(tab[i].e_ovf));
        end
        drive(0, 8'd0, 0, 0);
        tick();

        // Alternating 0/15 over one window: sum 240 -> 0x0780.
        drive(0, 8'd0, 1, 0);
        tick();
        for (int i = 0; i < WIN; i++) begin
            drive(1, (i % 2 == 1) ? 8'd15 : 8'd0, 0, 0);
            tick();
        end
        chk("alt.valid", int'(OUT_VALID), 1);
        chk("alt.data",  int'(OUT_DATA),  16'h0780);
        drive(0, 8'd0, 0, 1);
        tick();
        chk("alt.drained", int'(OUT_VALID), 0);

        // Async reset mid-window discards the partial sum.
        for (int i = 0; i < 10; i++) begin
            drive(1, 8'd9, 0, 0);
            tick();
        end
        drive(0, 8'd0, 0, 0);
        n_RES = 1'b0;
        model_reset();
        #2;
        chk("midrst.valid", int'(OUT_VALID), 0);
        chk("midrst.data",  int'(OUT_DATA),  0);
        chk("midrst.level", int'(LEVEL),     0);
        chk("midrst.ovf",   int'(OVF),       0);
        n_RES = 1'b1;
        for (int i = 0; i < WIN - 1; i++) begin
            drive(1, 8'd1, 0, 0);
            tick();
        end
        chk("midrst.partial_level", int'(LEVEL), 0);
        drive(1, 8'd1, 0, 0);
        tick();
        chk("midrst.word",  int'(OUT_DATA), 16'h0100);
        chk("midrst.level", int'(LEVEL),    1);
        drive(0, 8'd0, 0, 1);
        tick();
        chk("midrst.single", int'(OUT_VALID), 0);

        // Randomized traffic against the model; ready bias varies per phase.
        rdy_pct = 50;
        for (int c = 0; c < 6000; c++) begin
            if (c % 600 == 0) rdy_pct = $urandom_range(5, 95);
            drive($urandom_range(0, 99) < 75,
                  8'($urandom_range(0, 255)),
                  $urandom_range(0, 399) == 0,
                  $urandom_range(0, 99) < rdy_pct);
            tick();
            chk_model($sformatf("rnd%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
